// File: rtl/apb2_master.sv
// APB2 master: accepts one command at a time, runs SETUP/ACCESS with a
// bounded wait-state timeout and returns the result through a response handshake.
module apb2_master #(
    parameter int data_width     = 32,
    parameter int addr_width     = 8,
    parameter int timeout_cycles = 16
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [addr_width-1:0]   cmd_addr,
    input  logic [data_width-1:0]   cmd_wdata,
    input  logic [data_width/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [data_width-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [addr_width-1:0]   paddr,
    output logic [data_width-1:0]   pwdata,
    output logic [data_width/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [data_width-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // Count value on which a further pready=0 edge aborts the transfer.
    localparam logic [7:0] TO_LAST = 8'(timeout_cycles - 1);

    logic [1:0]              r_state;
    logic [7:0]              r_cnt;
    logic                    r_cmd_ready;
    logic                    r_rsp_valid;
    logic [data_width-1:0]   r_rsp_rdata;
    logic                    r_rsp_slverr;
    logic                    r_rsp_timeout;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [addr_width-1:0]   r_paddr;
    logic [data_width-1:0]   r_pwdata;
    logic [data_width/8-1:0] r_pstrb;

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_cmd_ready && cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_SETUP;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_cnt       <= '0;
                        r_pwrite    <= cmd_write;
                        r_paddr     <= cmd_addr;
                        // Reads never expose stale write data or strobes on the bus.
                        r_pwdata    <= cmd_write ? cmd_wdata : '0;
                        r_pstrb     <= cmd_write ? cmd_strb : '0;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_slverr  <= pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                        r_state       <= S_RESP;
                    end else if (r_cnt == TO_LAST) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_slverr  <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_slverr  = r_rsp_slverr;
    assign rsp_timeout = r_rsp_timeout;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pstrb       = r_pstrb;
    assign pprot       = 3'b000;

endmodule

// File: tb/tb_apb2_master.sv
// Bench for apb2_master: a scripted APB slave, a response scoreboard and
// per-scenario tasks with inline comparisons.
module tb_apb2_master;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata = '0;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready = 1'b0, pslverr = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
    } rsp_t;

    typedef struct packed {
        logic        done, setup_pen, unstable, bad_pen, ready_busy, rsp_unstable;
        logic        post_valid, post_ready, pwrite;
        logic [7:0]  acc_wait, psel_n, pen_n, psel_t, rsp_at, rsp_n, paddr;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        rsp_t        rsp;
    } obs_t;

    rsp_t exp_q[$];

    apb2_master #(.data_width(32), .addr_width(8), .timeout_cycles(4)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Sample t=0 is the cycle in which the command is accepted.
    task automatic run_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                            input logic [3:0] st, input int waits, input logic err,
                            input logic [31:0] rd, input int hold, input logic keep,
                            output obs_t o);
        int t, acc, vcnt;
        logic hs;
        o = '0;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 20) begin step(); t++; end
        o.acc_wait = 8'(t);
        if (!cmd_ready) begin cmd_valid = 1'b0; return; end
        t = 0; acc = 0; vcnt = 0; hs = 1'b0;
        while (!o.done && t < 60) begin
            step(); t++;
            if (!keep) cmd_valid = 1'b0;
            if (hs) begin
                o.done = 1'b1; o.post_valid = rsp_valid; o.post_ready = cmd_ready;
                rsp_ready = 1'b0;
            end else begin
                if (cmd_ready) o.ready_busy = 1'b1;
                if (penable && !psel) o.bad_pen = 1'b1;
                if (psel) begin
                    if (o.psel_n == 0) begin
                        o.psel_t = 8'(t); o.setup_pen = penable; o.pwrite = pwrite;
                        o.paddr = paddr; o.pwdata = pwdata; o.pstrb = pstrb;
                    end else if ({pwrite, paddr, pwdata, pstrb} !== {o.pwrite, o.paddr, o.pwdata, o.pstrb})
                        o.unstable = 1'b1;
                    o.psel_n = o.psel_n + 8'd1;
                end
                if (penable) o.pen_n = o.pen_n + 8'd1;
                pready = 1'b0; pslverr = 1'b0; prdata = 32'hDEAD_BEEF;
                if (psel && penable) begin
                    if (acc == waits) begin pready = 1'b1; pslverr = err; prdata = rd; end
                    acc++;
                end
                if (rsp_valid) begin
                    if (o.rsp_n == 0) begin
                        o.rsp_at = 8'(t); o.rsp = {rsp_rdata, rsp_slverr, rsp_timeout};
                    end else if ({rsp_rdata, rsp_slverr, rsp_timeout} !== o.rsp)
                        o.rsp_unstable = 1'b1;
                    o.rsp_n = o.rsp_n + 8'd1;
                    rsp_ready = (vcnt >= hold);
                    hs = rsp_ready;
                    vcnt++;
                end
            end
        end
        pready = 1'b0; pslverr = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        preset_n = 1'b0; cmd_valid = 1'b1;
        step(); step();
        total++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, psel, penable,
             pwrite, paddr, pwdata, pstrb, pprot} !== '0) begin
            bad++;
            $display("FAIL reset_values: cmd_ready=%b rsp_valid=%b psel=%b penable=%b paddr=%h pwdata=%h pstrb=%h want all 0",
                     cmd_ready, rsp_valid, psel, penable, paddr, pwdata, pstrb);
        end
        cmd_valid = 1'b0; preset_n = 1'b1;
        step();
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
        $display("reset: checked");
    endtask

    task automatic test_write();
        obs_t o; rsp_t e;
        exp_q.push_back('{rdata: 32'h0, slverr: 1'b0, timeout: 1'b0});
        run_xfer(1'b1, 8'h00, 32'h1, 4'hF, 0, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, o);
        e = exp_q.pop_front();
        total++;
        if (!o.done || o.rsp !== e) begin bad++; $display("FAIL write_rsp: got %h done=%b want %h", o.rsp, o.done, e); end
        total++;
        if ({o.psel_n, o.pen_n, o.psel_t, o.rsp_at} !== {8'd2, 8'd1, 8'd1, 8'd3}) begin
            bad++; $display("FAIL write_timing: psel_n=%0d pen_n=%0d psel_t=%0d rsp_at=%0d want 2 1 1 3",
                            o.psel_n, o.pen_n, o.psel_t, o.rsp_at);
        end
        total++;
        if ({o.pwrite, o.paddr, o.pwdata, o.pstrb, o.setup_pen, pprot} !== {1'b1, 8'h00, 32'h1, 4'hF, 1'b0, 3'b000}) begin
            bad++; $display("FAIL write_bus: pwrite=%b paddr=%h pwdata=%h pstrb=%h setup_pen=%b pprot=%b want 1 00 00000001 f 0 000",
                            o.pwrite, o.paddr, o.pwdata, o.pstrb, o.setup_pen, pprot);
        end
        total++;
        if ({o.unstable, o.bad_pen, o.ready_busy, o.post_valid, o.post_ready} !== 5'b00001) begin
            bad++; $display("FAIL write_protocol: unstable=%b bad_pen=%b ready_busy=%b post_valid=%b post_ready=%b want 0 0 0 0 1",
                            o.unstable, o.bad_pen, o.ready_busy, o.post_valid, o.post_ready);
        end
        $display("write: addr=00 rsp=%h", o.rsp);
    endtask

    task automatic test_read_wait();
        obs_t o; rsp_t e;
        exp_q.push_back('{rdata: 32'h1, slverr: 1'b0, timeout: 1'b0});
        run_xfer(1'b0, 8'h00, 32'hFFFF_FFFF, 4'hF, 2, 1'b0, 32'h0000_0001, 0, 1'b0, o);
        e = exp_q.pop_front();
        total++;
        if (!o.done || o.rsp !== e) begin bad++; $display("FAIL read_rsp: got %h done=%b want %h", o.rsp, o.done, e); end
        total++;
        if ({o.psel_n, o.pen_n, o.rsp_at} !== {8'd4, 8'd3, 8'd5}) begin
            bad++; $display("FAIL read_timing: psel_n=%0d pen_n=%0d rsp_at=%0d want 4 3 5", o.psel_n, o.pen_n, o.rsp_at);
        end
        total++;
        if ({o.pwrite, o.pwdata, o.pstrb, o.unstable} !== {1'b0, 32'h0, 4'h0, 1'b0}) begin
            bad++; $display("FAIL read_bus: pwrite=%b pwdata=%h pstrb=%h unstable=%b want 0 00000000 0 0",
                            o.pwrite, o.pwdata, o.pstrb, o.unstable);
        end
        $display("read_wait: addr=00 rsp=%h", o.rsp);
    endtask

    task automatic test_error();
        obs_t o; rsp_t e;
        exp_q.push_back('{rdata: 32'h0, slverr: 1'b1, timeout: 1'b0});
        run_xfer(1'b1, 8'h04, 32'h1234_5678, 4'h3, 0, 1'b1, 32'h5555_5555, 0, 1'b0, o);
        e = exp_q.pop_front();
        total++;
        if (!o.done || o.rsp !== e) begin bad++; $display("FAIL error_rsp: got %h done=%b want %h", o.rsp, o.done, e); end
        total++;
        if ({o.paddr, o.pstrb} !== {8'h04, 4'h3}) begin
            bad++; $display("FAIL error_bus: paddr=%h pstrb=%h want 04 3", o.paddr, o.pstrb);
        end
        $display("error: addr=04 rsp=%h", o.rsp);
    endtask

    task automatic test_timeout();
        obs_t o; rsp_t e;
        exp_q.push_back('{rdata: 32'h0, slverr: 1'b1, timeout: 1'b1});
        run_xfer(1'b0, 8'h08, 32'h0, 4'h0, -1, 1'b0, 32'h0, 0, 1'b0, o);
        e = exp_q.pop_front();
        total++;
        if (!o.done || o.rsp !== e) begin bad++; $display("FAIL timeout_rsp: got %h done=%b want %h", o.rsp, o.done, e); end
        total++;
        if ({o.psel_n, o.pen_n, o.rsp_at, o.bad_pen} !== {8'd5, 8'd4, 8'd6, 1'b0}) begin
            bad++; $display("FAIL timeout_timing: psel_n=%0d pen_n=%0d rsp_at=%0d bad_pen=%b want 5 4 6 0",
                            o.psel_n, o.pen_n, o.rsp_at, o.bad_pen);
        end
        $display("timeout: addr=08 rsp=%h", o.rsp);
        // pready arriving on the edge the counter would expire completes normally.
        exp_q.push_back('{rdata: 32'hA5A5_0004, slverr: 1'b0, timeout: 1'b0});
        run_xfer(1'b0, 8'h0C, 32'h0, 4'h0, 3, 1'b0, 32'hA5A5_0004, 0, 1'b0, o);
        e = exp_q.pop_front();
        total++;
        if (!o.done || o.rsp !== e) begin bad++; $display("FAIL timeout_edge_rsp: got %h done=%b want %h", o.rsp, o.done, e); end
        total++;
        if (o.pen_n !== 8'd4) begin bad++; $display("FAIL timeout_edge_pen: got %0d want 4", o.pen_n); end
        $display("timeout_edge: addr=0c rsp=%h", o.rsp);
    endtask

    task automatic test_back_to_back();
        obs_t o; rsp_t e;
        exp_q.push_back('{rdata: 32'hCAFE_0010, slverr: 1'b0, timeout: 1'b0});
        run_xfer(1'b0, 8'h10, 32'h0, 4'h0, 1, 1'b0, 32'hCAFE_0010, 5, 1'b1, o);
        e = exp_q.pop_front();
        total++;
        if (!o.done || o.rsp !== e) begin bad++; $display("FAIL bp_rsp: got %h done=%b want %h", o.rsp, o.done, e); end
        total++;
        if ({o.rsp_n, o.rsp_unstable, o.ready_busy, o.post_valid, o.post_ready} !== {8'd6, 4'b0001}) begin
            bad++; $display("FAIL bp_hold: rsp_n=%0d rsp_unstable=%b ready_busy=%b post_valid=%b post_ready=%b want 6 0 0 0 1",
                            o.rsp_n, o.rsp_unstable, o.ready_busy, o.post_valid, o.post_ready);
        end
        $display("backpressure: addr=10 rsp=%h", o.rsp);
        exp_q.push_back('{rdata: 32'h0, slverr: 1'b0, timeout: 1'b0});
        run_xfer(1'b1, 8'h14, 32'h0BAD_F00D, 4'h1, 0, 1'b0, 32'h0, 0, 1'b0, o);
        e = exp_q.pop_front();
        total++;
        if (!o.done || o.rsp !== e || o.acc_wait !== 8'd0 || o.paddr !== 8'h14) begin
            bad++; $display("FAIL b2b_next: rsp=%h done=%b acc_wait=%0d paddr=%h want %h 1 0 14",
                            o.rsp, o.done, o.acc_wait, o.paddr, e);
        end
        $display("back_to_back: addr=14 rsp=%h", o.rsp);
    endtask

    task automatic test_reset_mid_access();
        obs_t o; rsp_t e;
        int t;
        cmd_write = 1'b0; cmd_addr = 8'h20; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 20) begin step(); t++; end
        step(); cmd_valid = 1'b0;
        step();
        total++;
        if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL mid_access_reach: psel=%b penable=%b want 1 1", psel, penable); end
        preset_n = 1'b0;
        step();
        total++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000) begin
            bad++; $display("FAIL mid_reset_clear: psel=%b penable=%b rsp_valid=%b cmd_ready=%b want 0 0 0 0",
                            psel, penable, rsp_valid, cmd_ready);
        end
        preset_n = 1'b1;
        step();
        total++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL mid_reset_release: cmd_ready=%b rsp_valid=%b want 1 0", cmd_ready, rsp_valid);
        end
        exp_q.push_back('{rdata: 32'h0000_0024, slverr: 1'b0, timeout: 1'b0});
        run_xfer(1'b0, 8'h24, 32'h0, 4'h0, 0, 1'b0, 32'h0000_0024, 0, 1'b0, o);
        e = exp_q.pop_front();
        total++;
        if (!o.done || o.rsp !== e) begin bad++; $display("FAIL mid_reset_recover: got %h done=%b want %h", o.rsp, o.done, e); end
        $display("reset_mid_access: recovered rsp=%h", o.rsp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb2_master.md
APB2_MASTER -- requirements
Module: apb2_master

Interface
REQ-001 SHALL have parameter data_width, default 32, APB data bus width in bits.
REQ-002 SHALL have parameter addr_width, default 8, APB address width in bits.
REQ-003 SHALL have parameter timeout_cycles, default 16, maximum number of ACCESS cycles with pready low before abort; legal range 1..255.
REQ-004 SHALL have port pclk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port preset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports cmd_valid input 1 / cmd_ready output 1  command handshake.
REQ-007 SHALL have ports cmd_write input 1, cmd_addr input addr_width, cmd_wdata input data_width, cmd_strb input data_width/8  command payload.
REQ-008 SHALL have ports rsp_valid output 1 / rsp_ready input 1  response handshake.
REQ-009 SHALL have ports rsp_rdata output data_width, rsp_slverr output 1, rsp_timeout output 1  response payload.
REQ-010 SHALL have APB outputs psel 1, penable 1, pwrite 1, paddr addr_width, pwdata data_width, pstrb data_width/8, pprot 3.
REQ-011 SHALL have APB inputs prdata data_width, pready 1, pslverr 1.

Function
REQ-012 SHALL implement states IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-013 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on an edge where cmd_valid=1 and cmd_ready=1.
REQ-014 On acceptance SHALL latch payload, enter SETUP: psel=1, penable=0, pwrite/paddr/pwdata from latched command.
REQ-015 SHALL drive pstrb=latched cmd_strb for writes and pstrb=0 for reads; pwdata SHALL be 0 for reads.
REQ-016 SHALL drive pprot=3'b000 at all times.
REQ-017 SHALL move SETUP -> ACCESS unconditionally after one cycle, setting penable=1, psel held 1.
REQ-018 SHALL hold psel, penable, pwrite, paddr, pwdata, pstrb constant from SETUP through the last ACCESS cycle.
REQ-019 In ACCESS, on an edge with pready=1: SHALL capture rsp_slverr=pslverr, rsp_rdata=prdata for reads (0 for writes), rsp_timeout=0, clear psel/penable, set rsp_valid=1, enter RESP.
REQ-020 SHALL count ACCESS cycles sampled with pready=0 (8-bit counter, cleared on entering SETUP); when count reaches timeout_cycles and pready=0: clear psel/penable, rsp_timeout=1, rsp_slverr=1, rsp_rdata=0, enter RESP.
REQ-021 pready=1 on the same edge the counter would expire SHALL be treated as normal completion (REQ-019 wins).
REQ-022 Minimum latency: psel rises the cycle after acceptance; with pready=1 in first ACCESS cycle, rsp_valid rises 3 cycles after the acceptance edge.
REQ-023 In RESP SHALL hold rsp_valid and payload stable until an edge with rsp_ready=1, then clear rsp_valid and return to IDLE (cmd_ready=1 next cycle).
REQ-024 SHALL NOT accept a new command before the previous response handshake completes (one outstanding transfer).
REQ-025 psel and penable SHALL be 0 in IDLE and RESP; penable SHALL never be 1 without psel.

Reset
REQ-026 On an edge with preset_n=0, SHALL enter IDLE regardless of state, including mid-ACCESS or RESP (transfer dropped, no response).
REQ-027 Reset values: cmd_ready=0 during reset then 1 first cycle after release; rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, pprot=0, timeout counter=0.

Verification
REQ-028 Write: cmd addr=0x00 wdata=0x1 strb=0xF, slave pready=1 first ACCESS -> psel 2 cycles, penable 1 cycle, pstrb=0xF, rsp_valid 3 cycles after accept, slverr=0, timeout=0.
REQ-029 Read with 2 wait states: addr=0x00, pready low 2 ACCESS cycles then high with prdata=0x00000001 -> penable 3 cycles, rsp_rdata=0x1, pstrb=0, pwdata=0.
REQ-030 Error: addr=0x04, slave returns pready=1 pslverr=1 -> rsp_slverr=1, rsp_timeout=0, rsp_rdata=0 for write.
REQ-031 Timeout: timeout_cycles=4, pready stuck 0 -> exactly 4 ACCESS cycles, then psel=0, rsp_timeout=1, rsp_slverr=1; pready=1 on 4th cycle instead -> normal completion.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles with cmd_valid=1 held -> rsp payload stable, cmd_ready=0 throughout, next command accepted only after rsp handshake.
REQ-033 Reset mid-ACCESS: preset_n=0 one edge while penable=1 -> psel=penable=0, rsp_valid=0 next cycle, cmd_ready=1 after release.
